operand_entry_sequencer: RTL
============================

Name: operand_entry_sequencer

Overview:
- Drives the operand-entry protocol of the board wrapper: presents four 16-bit operands (a, b, c, d) on switch lines and generates KEY[0] press/release pulses.
- Timing on both lines satisfies the switch debouncer and the wrapper's WAIT_x/GET_x/GOT_x capture FSM.
- Replaces manual switch entry for automated bring-up and regression of exam modules.
- Outputs connect directly to the wrapper's SW[16:0] and KEY[0] inputs.

Parameters:
- SETTLE_CYCLES, 2048: cycles the operand is held stable before the key press. Must exceed the debouncer threshold of 1000.
- HOLD_CYCLES, 2048: cycles key0_n is held low (pressed).
- GAP_CYCLES, 2048: cycles key0_n is held high after release, before the next operand.
- All three parameters are ≥1. Counter width is sized for the largest of them.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- go  in  1  start request, sampled only in IDLE
- op_a  in  16  first operand
- op_b  in  16  second operand
- op_c  in  16  third operand
- op_d  in  16  fourth operand
- sw_out  out  17  [15:0] operand value, [16] value-ready flag
- key0_n  out  1  emulated KEY[0], active low, idles high
- busy  out  1  sequence in progress
- index  out  2  operand being entered (0=a … 3=d)
- seq_done  out  1  one-cycle completion pulse

Behaviour:
- Reset, applied synchronously at the clock edge with rst=1, sets: state IDLE, sw_out=0, key0_n=1, busy=0, index=0, seq_done=0, counter=0.
- Reset has priority over all other events, including mid-sequence. key0_n returns high on the same edge.
- All outputs are registered. The FSM states are IDLE, SETUP, PRESS, GAP, DONE.
- IDLE:
  - go=1 at edge k latches op_a..op_d into internal registers.
  - Registered result after edge k: state=SETUP, busy=1, index=0, sw_out={1'b1, op_a}, counter=SETTLE_CYCLES-1.
  - Operand inputs may change after edge k without effect.
- SETUP:
  - Holds key0_n=1 and sw_out for exactly SETTLE_CYCLES cycles.
  - When counter reaches 0: go to PRESS, key0_n=0, counter=HOLD_CYCLES-1.
- PRESS:
  - key0_n=0 for exactly HOLD_CYCLES cycles. sw_out is unchanged.
  - When counter reaches 0: go to GAP, key0_n=1, sw_out[16]=0, counter=GAP_CYCLES-1.
- GAP:
  - key0_n=1 for exactly GAP_CYCLES cycles.
  - When counter reaches 0 and index<3: index+1, sw_out={1'b1, next latched operand}, go to SETUP.
  - When counter reaches 0 and index==3: go to DONE.
- DONE (one cycle): seq_done=1, busy=0. sw_out[15:0] keeps op_d, sw_out[16]=0. The next state is IDLE.
- Latency: seq_done is high in the cycle starting at edge k+1+4·(SETTLE+HOLD+GAP).
- go is ignored whenever state≠IDLE, including during DONE. go held high continuously restarts a sequence in the cycle after DONE.
- In IDLE, sw_out holds its last value and key0_n=1.
- key0_n must never be low in any cycle where sw_out[15:0] differs from its value in the preceding cycle. The bench asserts this.

Optional Feature:
- Macro: SEQ_ABORT_EN.
- With SEQ_ABORT_EN defined:
  - Adds input abort (1 bit).
  - abort=1 in SETUP/PRESS/GAP forces, on the next edge: key0_n=1, sw_out=0, busy=0, index=0, state=IDLE.
  - An abort also pulses the extra output aborted (1 bit) for one cycle. seq_done is not asserted.
  - If abort and go are both high in IDLE, go wins. abort is ignored in IDLE and DONE.
- Without SEQ_ABORT_EN: neither port exists, and a sequence always runs to DONE unless rst is asserted.

Test Plan (SETTLE=2, HOLD=4, GAP=3 unless noted):
- Reset 3 cycles, then idle 5 cycles -> sw_out=0, key0_n=1, busy=0, seq_done=0 throughout.
- Pulse go with a=16'h1234, b=16'hABCD, c=16'h0001, d=16'hFFFF ->
  - exactly four key0_n low pulses, each 4 cycles wide, 5 cycles apart;
  - sw_out[15:0] during each pulse is 1234, ABCD, 0001, FFFF in order;
  - seq_done pulses 37 cycles after the go edge.
- Change op_a to 16'h0000 one cycle after go -> the first press still carries 16'h1234. A go during busy has no effect on the pulse count.
- Assert rst during the second PRESS -> next cycle key0_n=1, sw_out=0, busy=0. A new go then restarts from index 0.
- Default parameters, full wrapper + debouncer + adder exam module, a=5, b=7, c=2, d=3 ->
  - wrapper registers a..d match the inputs;
  - start=1;
  - g=12, h=6 after done.
- With SEQ_ABORT_EN defined: abort in the third GAP -> aborted pulses, seq_done stays 0, key0_n=1, state returns to IDLE.

Source files
------------

// File: rtl/operand_entry_sequencer.sv
// operand_entry_sequencer: drives the board wrapper's operand-entry protocol.
// Presents four latched 16-bit operands on sw_out and emulates KEY[0] press/release
// with settle, hold and gap timing long enough for the switch debouncer.
// Optional feature: define SEQ_ABORT_EN to add the abort input and aborted pulse output.

module operand_entry_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2048,
  parameter int unsigned HOLD_CYCLES   = 2048,
  parameter int unsigned GAP_CYCLES    = 2048
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
`ifdef SEQ_ABORT_EN
  input  logic        abort,
  output logic        aborted,
`endif
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  input  logic [15:0] op_c,
  input  logic [15:0] op_d,
  output logic [16:0] sw_out,
  output logic        key0_n,
  output logic        busy,
  output logic [1:0]  index,
  output logic        seq_done
);

  localparam int unsigned MaxCycles =
      (SETTLE_CYCLES > HOLD_CYCLES) ?
      ((SETTLE_CYCLES > GAP_CYCLES) ? SETTLE_CYCLES : GAP_CYCLES) :
      ((HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES);
  localparam int unsigned CntW = $clog2(MaxCycles + 1);

  localparam logic [CntW-1:0] SettleLoad = CntW'(SETTLE_CYCLES - 1);
  localparam logic [CntW-1:0] HoldLoad   = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] GapLoad    = CntW'(GAP_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne     = CntW'(1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StSetup = 3'd1;
  localparam logic [2:0] StPress = 3'd2;
  localparam logic [2:0] StGap   = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [16:0]      sw_q, sw_d;
  logic             key_q, key_d;
  logic             busy_q, busy_d;
  logic [1:0]       index_q, index_d;
  logic             done_q, done_d;
  logic [3:0][15:0] ops_q, ops_d;
  logic [1:0]       next_index;
`ifdef SEQ_ABORT_EN
  logic             aborted_q, aborted_d;
`endif

  assign next_index = index_q + 2'd1;

  // Next-state logic: one operand per SETUP/PRESS/GAP round, four rounds, then DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sw_d    = sw_q;
    key_d   = key_q;
    busy_d  = busy_q;
    index_d = index_q;
    done_d  = 1'b0;
    ops_d   = ops_q;
    case (state_q)
      StIdle: begin
        key_d = 1'b1;
        if (go) begin
          // Operands are captured here so later input changes cannot disturb entry.
          ops_d   = {op_d, op_c, op_b, op_a};
          state_d = StSetup;
          busy_d  = 1'b1;
          index_d = 2'd0;
          sw_d    = {1'b1, op_a};
          cnt_d   = SettleLoad;
        end
      end
      StSetup: begin
        if (cnt_q == '0) begin
          state_d = StPress;
          key_d   = 1'b0;
          cnt_d   = HoldLoad;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StPress: begin
        if (cnt_q == '0) begin
          state_d  = StGap;
          key_d    = 1'b1;
          sw_d[16] = 1'b0;
          cnt_d    = GapLoad;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StGap: begin
        if (cnt_q == '0) begin
          if (index_q != 2'd3) begin
            index_d = next_index;
            sw_d    = {1'b1, ops_q[next_index]};
            state_d = StSetup;
            cnt_d   = SettleLoad;
          end else begin
            state_d = StDone;
          end
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StDone: begin
        done_d   = 1'b1;
        busy_d   = 1'b0;
        sw_d[16] = 1'b0;
        state_d  = StIdle;
      end
      default: begin
        state_d = StIdle;
        key_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
`ifdef SEQ_ABORT_EN
    aborted_d = 1'b0;
    // Abort only applies while a round is active; IDLE and DONE ignore it.
    if (abort && (state_q == StSetup || state_q == StPress || state_q == StGap)) begin
      state_d   = StIdle;
      key_d     = 1'b1;
      sw_d      = '0;
      busy_d    = 1'b0;
      index_d   = 2'd0;
      cnt_d     = '0;
      aborted_d = 1'b1;
    end
`endif
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      sw_q      <= '0;
      key_q     <= 1'b1;
      busy_q    <= 1'b0;
      index_q   <= 2'd0;
      done_q    <= 1'b0;
      ops_q     <= '0;
`ifdef SEQ_ABORT_EN
      aborted_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sw_q      <= sw_d;
      key_q     <= key_d;
      busy_q    <= busy_d;
      index_q   <= index_d;
      done_q    <= done_d;
      ops_q     <= ops_d;
`ifdef SEQ_ABORT_EN
      aborted_q <= aborted_d;
`endif
    end
  end

  assign sw_out   = sw_q;
  assign key0_n   = key_q;
  assign busy     = busy_q;
  assign index    = index_q;
  assign seq_done = done_q;
`ifdef SEQ_ABORT_EN
  assign aborted  = aborted_q;
`endif

endmodule
